// File: rtl/rv32_pkg.sv
// Shared RV32 core types: data-memory responder state, request bundle.
// Ports: none (package).
package rv32_pkg;

  localparam int XLEN        = 32;
  localparam int DMEM_DATA_W = XLEN;
  localparam int DMEM_BE_W   = DMEM_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  typedef struct packed {
    logic [XLEN-1:0]        addr;
    logic                   we;
    logic [DMEM_BE_W-1:0]   be;
    logic [DMEM_DATA_W-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_sram_array.sv
// Single-port DEPTH x DATA_W scratchpad, byte-enable write, registered read.
// Ports: clk_i, en_i, we_i, be_i, idx_i, wdata_i, rdata_o (valid after en_i edge).
module dmem_sram_array #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 32
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic                     we_i,
  input  logic [DATA_W/8-1:0]      be_i,
  input  logic [$clog2(DEPTH)-1:0] idx_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < BE_W; b++) begin
          if (be_i[b]) begin
            mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end else begin
        rdata_q <= mem[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-side memory responder: one request at a time, fixed wait states.
// Ports: clk_i, rst_i, req_* (valid/ready/addr/we/be/wdata), rsp_* (valid/ready/rdata/err).
// Optional address range fault: define DMEM_RANGE_CHECK_EN.
module dmem_responder
  import rv32_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic                req_we_i,
  input  logic [DATA_W/8-1:0] req_be_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic                rsp_err_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int BE_W  = DATA_W / 8;
  localparam logic [3:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  dmem_state_t state_q, state_d;
  logic [3:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;
  logic              load_q;
  logic              err_q;

  logic              idle;
  logic              accept;
  logic              commit;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_err;
  logic [DATA_W-1:0] sram_rdata;
  logic              unused;

  assign idle   = (state_q == IDLE);
  assign accept = idle && req_valid_i;
  // Entry into RESP; from IDLE only when WAIT_CYCLES is 0.
  assign commit = (state_d == RESP) && (state_q != RESP);

  // Zero-wait commits happen on the accept edge, before capture.
  assign sel_addr  = idle ? req_addr_i  : addr_q;
  assign sel_we    = idle ? req_we_i    : we_q;
  assign sel_be    = idle ? req_be_i    : be_q;
  assign sel_wdata = idle ? req_wdata_i : wdata_q;

`ifdef DMEM_RANGE_CHECK_EN
  assign sel_err = |sel_addr[ADDR_W-1:IDX_W+2];
`else
  assign sel_err = 1'b0;
`endif

  assign unused = ^{sel_addr[1:0], sel_addr[ADDR_W-1:IDX_W+2]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req_valid_i)
              state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT: if (cnt_q == 4'd0) state_d = RESP;
      RESP: if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q   <= CNT_INIT;
        addr_q  <= req_addr_i;
        we_q    <= req_we_i;
        be_q    <= req_be_i;
        wdata_q <= req_wdata_i;
      end else if (state_q == WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (commit) begin
        load_q <= !sel_we && !sel_err;
        err_q  <= sel_err;
      end
    end
  end

  dmem_sram_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_sram (
    .clk_i   (clk_i),
    .en_i    (commit),
    .we_i    (sel_we && !sel_err),
    .be_i    (sel_be),
    .idx_i   (sel_addr[IDX_W+1:2]),
    .wdata_i (sel_wdata),
    .rdata_o (sram_rdata)
  );

  assign req_ready_o = idle;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_rdata_o = (rsp_valid_o && load_q) ? sram_rdata : '0;
  assign rsp_err_o   = rsp_valid_o && err_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-side memory responder, the target end of the mem_stage data-cache request/response interface.
- Accepts one load/store request at a time.
- Services it from an internal word-addressed scratchpad after a fixed number of wait states.
- Holds the response until the pipeline accepts it.
- Serves as the data memory for core bring-up and as the back end the data cache will later front.

Parameters:
- ADDR_W, 32, request address width in bits
- DATA_W, 32, data width in bits; must be a multiple of 8
- DEPTH, 1024, scratchpad size in DATA_W words; power of two
- WAIT_CYCLES, 1, wait states between request accept and response; range 0..15

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- req_valid_i  in  1  request valid
- req_ready_o  out  1  responder can accept a request
- req_addr_i  in  ADDR_W  byte address; bits [1:0] ignored, initiator aligns
- req_we_i  in  1  1 = store, 0 = load
- req_be_i  in  DATA_W/8  byte enables for stores
- req_wdata_i  in  DATA_W  store data, already lane-shifted by initiator
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  initiator accepts response
- rsp_rdata_o  out  DATA_W  full load word; sign/zero extension is the initiator's job
- rsp_err_o  out  1  access fault for this response

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is asynchronous, active-high.
- Reset values: state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, wait counter 0. Scratchpad contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, capture addr, we, be, wdata into registers.
  - Go to WAIT, loading the counter with WAIT_CYCLES-1; go straight to RESP if WAIT_CYCLES=0.
- WAIT:
  - req_ready_o=0.
  - Counter decrements each cycle; at 0, go to RESP.
- Commit point (the cycle of entry into RESP):
  - Store: write bytes where be=1; other bytes keep their old value. be=0 writes nothing and still responds.
  - Load: rsp_rdata_o loaded with the word at the captured index.
  - Store response: rsp_rdata_o=0.
- RESP:
  - rsp_valid_o=1; rsp_rdata_o and rsp_err_o held stable until rsp_ready_i=1.
  - On handshake, rsp_valid_o drops next cycle and the FSM returns to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- Latency and throughput:
  - Accept edge to rsp_valid_o high = WAIT_CYCLES+1 cycles.
  - Minimum request spacing is WAIT_CYCLES+2 cycles with rsp_ready_i tied high.
- Word index = req_addr_i[2+$clog2(DEPTH)-1:2]. Upper bits are ignored, so the address wraps modulo DEPTH words, unless the optional feature is enabled.
- Only one request is outstanding. req_valid_i outside IDLE is ignored, and the initiator must hold it.
- Load to the same word as the immediately preceding store returns the new data.
- Reset mid-operation:
  - In WAIT, the pending store is dropped and the memory is unchanged.
  - In RESP, the response is dropped.
  - Next cycle after reset release, the FSM is in IDLE.

Optional Feature:
DMEM_RANGE_CHECK_EN
- Defined:
  - Requests whose address bits above the index field are non-zero are faults.
  - Fault response: rsp_err_o=1, rsp_rdata_o=0, no write, same latency.
  - The initiator maps rsp_err_o to its access-fault exception.
- Undefined: no check, addresses wrap, and rsp_err_o is tied 0.

Decomposition:
- rv32_pkg additions:
  - dmem_state_t enum (IDLE, WAIT, RESP).
  - Constant DMEM_BE_W = DATA_W/8.
  - Packed struct dmem_req_t {addr, we, be, wdata}, reused by mem_stage for its request register.
- Sub-module dmem_sram_array:
  - Ports: DEPTH x DATA_W, one read/write port, byte-enable write, registered read data.
  - Kept separate so it can be swapped for an FPGA BRAM macro.
- FSM and handshakes stay in dmem_responder.

Test Plan:
- Store addr 0x10, be=4'hF, wdata 0xDEADBEEF; then load 0x10 (WAIT_CYCLES=1) -> rsp_valid_o at cycle 2 after accept, rdata 0xDEADBEEF, err 0.
- Store 0x10 be=4'b0100 wdata 0x00AA0000 over 0xDEADBEEF; load 0x10 -> 0xDEAABEEF.
- Load with rsp_ready_i held low 5 cycles -> rsp_valid_o, rsp_rdata_o stable all 5 cycles; req_ready_o=0 throughout; IDLE one cycle after handshake.
- WAIT_CYCLES=0, rsp_ready_i=1, back-to-back loads -> response 1 cycle after each accept, accepts spaced 2 cycles apart.
- Assert rst_i during WAIT of store to 0x20 (old value 0x12345678) -> after release, load 0x20 returns 0x12345678, rsp_valid_o=0 right after reset.
- DMEM_RANGE_CHECK_EN, DEPTH=1024: store to 0x0000_1000 -> rsp_err_o=1, rdata 0, word 0 unchanged. Without the macro, the same store wraps and overwrites word 0.
